// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//   Requester 0 is the pipeline EX stage and requester 1 is the multi-cycle/debug port.
//   Arbitration is round-robin. Operands and the result are registered, and the
//   response is held until the owning requester accepts it.
// Ports:
//   clk, rst_n                 clock (rising edge) and asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake; ready is combinational, IDLE winner only
//   reqN_a, reqN_b, reqN_func  request operands and function code
//   rspN_valid / rspN_ready    response handshake; only the owner's valid is raised
//   rsp_out, rsp_of, rsp_err   shared result, overflow flag and illegal-function flag
//   alu_a, alu_b, alu_func     registered operands driven to the external ALU
//   alu_out, alu_of            external ALU result and overflow
//   busy                       an operation is in flight (not IDLE)
//   of_sticky, of_clr          sticky overflow flag and its synchronous clear
module alu_arbiter #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned OUT_W    = 32,
   parameter int unsigned FUNC_W   = 3,
   parameter int unsigned MAX_FUNC = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [FUNC_W-1:0] req0_func,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [FUNC_W-1:0] req1_func,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [OUT_W-1:0]  rsp_out,
   output logic              rsp_of,
   output logic              rsp_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [OUT_W-1:0]  alu_out,
   input  logic              alu_of,
   output logic              busy,
   output logic              of_sticky,
   input  logic              of_clr
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state, state_nxt;
   logic              last_grant;
   logic              owner, owner_nxt;
   logic              winner_c;
   logic              hs_c;
   logic              illegal_c;
   logic              rsp_done_c;
   logic [DATA_W-1:0] win_a_c, win_b_c;
   logic [FUNC_W-1:0] win_func_c;

   // Round-robin winner selection and the combinational request handshake
   always_comb begin
      winner_c = 1'b0;
      if (req0_valid && req1_valid) begin
         winner_c = ~last_grant;
      end else if (req1_valid) begin
         winner_c = 1'b1;
      end
      hs_c       = (state == IDLE) && (req0_valid || req1_valid);
      req0_ready = hs_c && !winner_c;
      req1_ready = hs_c && winner_c;
      win_a_c    = winner_c ? req1_a    : req0_a;
      win_b_c    = winner_c ? req1_b    : req0_b;
      win_func_c = winner_c ? req1_func : req0_func;
      illegal_c  = (win_func_c > FUNC_W'(MAX_FUNC));
      rsp_done_c = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
   end

   // Next-state logic; an illegal function skips EXEC and responds directly
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         IDLE: begin
            if (hs_c) begin
               state_nxt = illegal_c ? RESP : EXEC;
               owner_nxt = winner_c;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_done_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, ownership and the status outputs derived from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         busy       <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         if (hs_c) last_grant <= winner_c;
         busy       <= (state_nxt != IDLE);
         rsp0_valid <= (state_nxt == RESP) && !owner_nxt;
         rsp1_valid <= (state_nxt == RESP) && owner_nxt;
      end
   end

   // Operand latch on grant; these hold their values until the next grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a    <= '0;
         alu_b    <= '0;
         alu_func <= '0;
      end else if (hs_c) begin
         alu_a    <= win_a_c;
         alu_b    <= win_b_c;
         alu_func <= win_func_c;
      end
   end

   // Response capture: the ALU result at the end of EXEC, or a zeroed error on an illegal grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_out <= '0;
         rsp_of  <= 1'b0;
         rsp_err <= 1'b0;
      end else if (hs_c && illegal_c) begin
         rsp_out <= '0;
         rsp_of  <= 1'b0;
         rsp_err <= 1'b1;
      end else if (state == EXEC) begin
         rsp_out <= alu_out;
         rsp_of  <= alu_of;
         rsp_err <= 1'b0;
      end
   end

   // Sticky overflow; a set in the same cycle as a clear takes priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         of_sticky <= 1'b0;
      end else if ((state == EXEC) && alu_of) begin
         of_sticky <= 1'b1;
      end else if (of_clr) begin
         of_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with an adder ALU stub.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0]  req0_func, req1_func;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_out;
   logic        rsp_of, rsp_err;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_func;
   logic [31:0] alu_out;
   logic        alu_of;
   logic        busy, of_sticky, of_clr;
   logic [16:0] alu_sum;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // ALU stub: zero-extended 17-bit sum, overflow is the carry out of bit 15
   always_comb begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      alu_out = {15'd0, alu_sum};
      alu_of  = alu_sum[16];
   end

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_func  (req0_func),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_func  (req1_func),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp_out    (rsp_out),
      .rsp_of     (rsp_of),
      .rsp_err    (rsp_err),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_func   (alu_func),
      .alu_out    (alu_out),
      .alu_of     (alu_of),
      .busy       (busy),
      .of_sticky  (of_sticky),
      .of_clr     (of_clr)
   );

   task automatic test_reset;
      rst_n = 1'b0;
      req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0; of_clr = 0;
      req0_a = 0; req0_b = 0; req0_func = 0; req1_a = 0; req1_b = 0; req1_func = 0;
      @(negedge clk); @(negedge clk); #1;
      vectors++; if (rsp0_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp0_valid got %b exp 0", rsp0_valid); end
      vectors++; if (rsp1_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp1_valid got %b exp 0", rsp1_valid); end
      vectors++; if (rsp_out !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_out got %h exp 0", rsp_out); end
      vectors++; if ({rsp_of, rsp_err, busy, of_sticky} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b exp 0000", {rsp_of, rsp_err, busy, of_sticky}); end
      vectors++; if ({alu_a, alu_b, alu_func} !== 35'd0) begin miscompares++; $display("FAIL reset_alu_regs got %h exp 0", {alu_a, alu_b, alu_func}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      @(negedge clk);
      req0_valid = 1; req0_a = 16'd5076; req0_b = 16'd200; req0_func = 3'b000;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_grant got %b exp 10", {req0_ready, req1_ready}); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_T got %b exp 0", busy); end
      @(negedge clk); #1;
      vectors++; if ({busy, req0_ready, rsp0_valid} !== 3'b100) begin miscompares++; $display("FAIL single_exec got %b exp 100", {busy, req0_ready, rsp0_valid}); end
      vectors++; if ({alu_a, alu_b} !== {16'd5076, 16'd200}) begin miscompares++; $display("FAIL single_alu_ops got %h exp %h", {alu_a, alu_b}, {16'd5076, 16'd200}); end
      @(negedge clk); #1;
      vectors++; if ({rsp0_valid, rsp1_valid, busy, req0_ready} !== 4'b1010) begin miscompares++; $display("FAIL single_resp_valid got %b exp 1010", {rsp0_valid, rsp1_valid, busy, req0_ready}); end
      vectors++; if (rsp_out !== 32'd5276) begin miscompares++; $display("FAIL single_rsp_out got %0d exp 5276", rsp_out); end
      vectors++; if ({rsp_of, rsp_err} !== 2'b00) begin miscompares++; $display("FAIL single_rsp_flags got %b exp 00", {rsp_of, rsp_err}); end
      req0_valid = 0; rsp0_ready = 1;
      @(negedge clk); #1;
      vectors++; if ({rsp0_valid, busy} !== 2'b00) begin miscompares++; $display("FAIL single_done got %b exp 00", {rsp0_valid, busy}); end
      vectors++; if (alu_a !== 16'd5076) begin miscompares++; $display("FAIL single_alu_hold got %0d exp 5076", alu_a); end
      rsp0_ready = 0;
   endtask

   task automatic test_overflow;
      @(negedge clk);
      req1_valid = 1; req1_a = 16'hcccc; req1_b = 16'hcccc; req1_func = 3'd1;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL ovf_grant got %b exp 01", {req0_ready, req1_ready}); end
      @(negedge clk);
      req1_valid = 0;
      @(negedge clk); #1;
      vectors++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin miscompares++; $display("FAIL ovf_valid got %b exp 01", {rsp0_valid, rsp1_valid}); end
      vectors++; if (rsp_out !== 32'h00019998) begin miscompares++; $display("FAIL ovf_rsp_out got %h exp 00019998", rsp_out); end
      vectors++; if ({rsp_of, of_sticky} !== 2'b11) begin miscompares++; $display("FAIL ovf_flags got %b exp 11", {rsp_of, of_sticky}); end
      rsp1_ready = 1;
      @(negedge clk); #1;
      vectors++; if ({rsp1_valid, of_sticky} !== 2'b01) begin miscompares++; $display("FAIL ovf_sticky_hold got %b exp 01", {rsp1_valid, of_sticky}); end
      rsp1_ready = 0; of_clr = 1;
      @(negedge clk); #1;
      vectors++; if (of_sticky !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", of_sticky); end
      of_clr = 0;
   endtask

   task automatic test_contention;
      logic exp1;
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      req0_valid = 1; req0_a = 16'd1;  req0_b = 16'd2;  req0_func = 3'd0;
      req1_valid = 1; req1_a = 16'd10; req1_b = 16'd20; req1_func = 3'd3;
      rsp0_ready = 1; rsp1_ready = 1;
      for (int i = 0; i < 4; i++) begin
         exp1 = (i % 2) == 1;
         #1;
         vectors++; if ({req0_ready, req1_ready} !== {~exp1, exp1}) begin miscompares++; $display("FAIL cont_grant%0d got %b exp %b", i, {req0_ready, req1_ready}, {~exp1, exp1}); end
         @(negedge clk); #1;
         vectors++; if ({req0_ready, req1_ready, busy} !== 3'b001) begin miscompares++; $display("FAIL cont_exec%0d got %b exp 001", i, {req0_ready, req1_ready, busy}); end
         @(negedge clk); #1;
         vectors++; if ({rsp0_valid, rsp1_valid} !== {~exp1, exp1}) begin miscompares++; $display("FAIL cont_owner%0d got %b exp %b", i, {rsp0_valid, rsp1_valid}, {~exp1, exp1}); end
         vectors++; if (rsp_out !== (exp1 ? 32'd30 : 32'd3)) begin miscompares++; $display("FAIL cont_rsp_out%0d got %0d exp %0d", i, rsp_out, exp1 ? 30 : 3); end
         if (i == 3) begin req0_valid = 0; req1_valid = 0; end
         @(negedge clk);
      end
      rsp0_ready = 0; rsp1_ready = 0;
   endtask

   task automatic test_backpressure_illegal;
      req0_valid = 1; req0_a = 16'd7; req0_b = 16'd9; req0_func = 3'b110;
      #1;
      vectors++; if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL ill_grant got %b exp 1", req0_ready); end
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_a = 16'd100; req1_b = 16'd23; req1_func = 3'd2; rsp1_ready = 1;
      for (int k = 0; k < 5; k++) begin
         #1;
         vectors++; if ({rsp0_valid, rsp1_valid, req1_ready, busy} !== 4'b1001) begin miscompares++; $display("FAIL ill_hold%0d got %b exp 1001", k, {rsp0_valid, rsp1_valid, req1_ready, busy}); end
         vectors++; if ({rsp_out, rsp_of, rsp_err} !== {32'd0, 1'b0, 1'b1}) begin miscompares++; $display("FAIL ill_rsp%0d got %h/%b/%b exp 0/0/1", k, rsp_out, rsp_of, rsp_err); end
         @(negedge clk);
      end
      #1;
      vectors++; if ({alu_a, alu_func, of_sticky} !== {16'd7, 3'b110, 1'b0}) begin miscompares++; $display("FAIL ill_latch got %h/%b/%b exp 7/110/0", alu_a, alu_func, of_sticky); end
      rsp0_ready = 1;
      @(negedge clk); #1;
      vectors++; if ({rsp0_valid, req1_ready} !== 2'b01) begin miscompares++; $display("FAIL ill_release got %b exp 01", {rsp0_valid, req1_ready}); end
      rsp0_ready = 0;
      @(negedge clk);
      req1_valid = 0;
      @(negedge clk); #1;
      vectors++; if ({rsp1_valid, rsp_err} !== 2'b10) begin miscompares++; $display("FAIL ill_next_valid got %b exp 10", {rsp1_valid, rsp_err}); end
      vectors++; if (rsp_out !== 32'd123) begin miscompares++; $display("FAIL ill_next_out got %0d exp 123", rsp_out); end
      @(negedge clk);
      rsp1_ready = 0;
   endtask

   task automatic test_reset_midop;
      req1_valid = 1; req1_a = 16'hffff; req1_b = 16'd1; req1_func = 3'd0;
      #1;
      vectors++; if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_grant got %b exp 1", req1_ready); end
      @(negedge clk);
      req1_valid = 0;
      rst_n = 0;
      #1;
      vectors++; if ({busy, rsp0_valid, rsp1_valid, rsp_of, rsp_err, of_sticky} !== 6'd0) begin miscompares++; $display("FAIL rmid_flags got %b exp 000000", {busy, rsp0_valid, rsp1_valid, rsp_of, rsp_err, of_sticky}); end
      vectors++; if ({rsp_out, alu_a, alu_b, alu_func} !== 67'd0) begin miscompares++; $display("FAIL rmid_data got %h exp 0", {rsp_out, alu_a, alu_b, alu_func}); end
      @(negedge clk);
      rst_n = 1; rsp1_ready = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         vectors++; if ({rsp0_valid, rsp1_valid, busy, of_sticky} !== 4'b0000) begin miscompares++; $display("FAIL rmid_stale%0d got %b exp 0000", k, {rsp0_valid, rsp1_valid, busy, of_sticky}); end
      end
      req0_valid = 1; req0_a = 16'd40; req0_b = 16'd2; req0_func = 3'd0;
      req1_valid = 1; req1_a = 16'd50; req1_b = 16'd3; req1_func = 3'd0;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL rmid_cont got %b exp 10", {req0_ready, req1_ready}); end
      @(negedge clk);
      req0_valid = 0; req1_valid = 0; rsp0_ready = 1;
      @(negedge clk); #1;
      vectors++; if ({rsp0_valid, rsp1_valid, rsp_out} !== {2'b10, 32'd42}) begin miscompares++; $display("FAIL rmid_resp got %b/%0d exp 10/42", {rsp0_valid, rsp1_valid}, rsp_out); end
      @(negedge clk);
      rsp0_ready = 0; rsp1_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_contention();
      test_backpressure_illegal();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (16-bit operands, 3-bit function code, 32-bit result, overflow flag) between two requesters: requester 0 is the pipeline EX stage, requester 1 is the multi-cycle/debug port.
- Round-robin arbitration, valid/ready request handshake, registered operands and result, and a held response with backpressure.
- Sits between the requesters and the ALU instance; the ALU itself is external.

Parameters:
- DATA_W, 16, operand width.
- OUT_W, 32, result width.
- FUNC_W, 3, function-code width.
- MAX_FUNC, 5, highest legal function code; codes above it are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_func / req1_func  in  FUNC_W  ALU function code.
- rsp0_valid / rsp1_valid  out  1  result available to that requester.
- rsp0_ready / rsp1_ready  in  1  requester consumes result.
- rsp_out  out  OUT_W  result (shared; qualified by rspN_valid).
- rsp_of  out  1  overflow flag of result.
- rsp_err  out  1  illegal function code; result forced to 0.
- alu_a, alu_b  out  DATA_W  ALU operands (registered).
- alu_func  out  FUNC_W  ALU function (registered).
- alu_out  in  OUT_W  ALU result.
- alu_of  in  1  ALU overflow.
- busy  out  1  state != IDLE.
- of_sticky  out  1  set when any completed op had of=1.
- of_clr  in  1  synchronous clear of of_sticky.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; all rspN_valid=0; rsp_out=0, rsp_of=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_func=0; busy=0; of_sticky=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Reset mid-operation abandons the op; no response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, only for the winner.
  - Winner: the sole valid requester; if both are valid, the one not equal to last_grant.
  - On handshake: latch a, b, func into alu_a/alu_b/alu_func; owner<=winner; last_grant<=winner.
  - Next state: EXEC if func<=MAX_FUNC, else RESP with rsp_out=0, rsp_of=0, rsp_err=1.
  - The loser sees ready=0 and must hold its request stable.
- EXEC (exactly one cycle):
  - The ALU sees registered operands.
  - At the clock edge capture rsp_out<=alu_out, rsp_of<=alu_of, rsp_err<=0; go to RESP.
- RESP:
  - rsp_owner_valid=1; the other rsp valid stays 0.
  - Hold rsp_out, rsp_of and rsp_err stable until rsp_owner_ready=1, then return to IDLE.
  - rspN_ready for the non-owner is ignored.
- Latency:
  - Request handshake in cycle T → rsp_valid in cycle T+2 (legal func) or T+1 (illegal).
  - A new request can be accepted in the cycle after the response handshake.
  - Peak throughput: one op per 3 cycles.
- No request is accepted while busy; reqN_ready=0 in EXEC and RESP.
- alu_a, alu_b and alu_func hold their last values outside EXEC; they do not return to 0.
- of_sticky:
  - Set on the EXEC→RESP edge when alu_of=1.
  - of_clr clears it; if a set and a clear occur in the same cycle, set wins.
  - Illegal ops never set it.
- Simultaneous events: both requests valid in IDLE with last_grant=0 → requester 1 wins, then requester 0 is served next if it is still valid.

Test Plan:
- Bench ALU stub: alu_out = a+b zero-extended; alu_of = carry out of bit 15.
- Single op: req0 a=5076, b=200, func=000 → req0_ready in cycle T; rsp0_valid in T+2; rsp_out=5276, rsp_of=0; busy high T+1..T+2.
- Overflow: req1 a=16'hcccc, b=16'hcccc → rsp_out=32'h00019998, rsp_of=1, of_sticky=1. Then of_clr=1 → of_sticky=0.
- Contention: both valid from reset → grants in the order 0,1,0,1 over four ops; each response arrives only on its owner's rsp valid.
- Backpressure / illegal func: req0 func=3'b110 with rsp0_ready=0 for 5 cycles → rsp0_valid held 5 cycles; rsp_err=1, rsp_out=0; no new grant until rsp0_ready=1.
- Reset mid-op: rst_n pulsed low during EXEC → all outputs at reset values immediately; no stale response after rst_n rises; next contention granted to requester 0.
